// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART receiver byte stream into checked
// SYNC/CMD/LEN/payload/CHECKSUM command frames.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rec,
  input  logic [7:0] uart_data_in,
  output logic [7:0] frm_cmd,
  output logic [7:0] frm_len,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       frm_done,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  state_t          state;
  logic            rec_last;
  logic [7:0]      csum;
  logic [7:0]      cnt;
  logic [TO_W-1:0] to_cnt;
  logic            stb;
  logic            to_hit;

  assign stb    = uart_rec & ~rec_last;
  assign busy   = (state != S_IDLE);
  assign to_hit = busy &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      rec_last <= 1'b0;
      csum     <= 8'd0;
      cnt      <= 8'd0;
      to_cnt   <= '0;
      frm_cmd  <= 8'd0;
      frm_len  <= 8'd0;
      pl_data  <= 8'd0;
      pl_valid <= 1'b0;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
      err_code <= 2'd0;
    end else begin
      rec_last <= uart_rec;
      pl_valid <= 1'b0;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
      if (stb || state == S_IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);
      // A byte arriving on the timeout cycle takes priority.
      if (stb) begin
        unique case (state)
          S_IDLE: begin
            if (uart_data_in == SYNC_BYTE)
              state <= S_CMD;
          end
          S_CMD: begin
            frm_cmd <= uart_data_in;
            csum    <= uart_data_in;
            state   <= S_LEN;
          end
          S_LEN: begin
            frm_len <= uart_data_in;
            csum    <= csum + uart_data_in;
            if (uart_data_in > 8'(MAX_LEN)) begin
              frm_err  <= 1'b1;
              err_code <= 2'd2;
              state    <= S_IDLE;
            end else if (uart_data_in == 8'd0) begin
              state <= S_CSUM;
            end else begin
              cnt   <= 8'd0;
              state <= S_PAY;
            end
          end
          S_PAY: begin
            pl_data  <= uart_data_in;
            pl_valid <= 1'b1;
            csum     <= csum + uart_data_in;
            cnt      <= cnt + 8'd1;
            if (cnt == frm_len - 8'd1)
              state <= S_CSUM;
          end
          S_CSUM: begin
            if (uart_data_in == csum) begin
              frm_done <= 1'b1;
            end else begin
              frm_err  <= 1'b1;
              err_code <= 2'd1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (to_hit) begin
        frm_err  <= 1'b1;
        err_code <= 2'd3;
        state    <= S_IDLE;
        to_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed and random frames against a
// frame-position reference model.
module tb_uart_frame_parser;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rec = 1'b0;
  logic [7:0] uart_data_in = 8'd0;
  logic [7:0] frm_cmd, frm_len, pl_data;
  logic       pl_valid, frm_done, frm_err, busy;
  logic [1:0] err_code;

  uart_frame_parser dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_rec     (uart_rec),
    .uart_data_in (uart_data_in),
    .frm_cmd      (frm_cmd),
    .frm_len      (frm_len),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .frm_done     (frm_done),
    .frm_err      (frm_err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int npl, ndone, nerr;
  int stb_cyc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: tracks position within the frame buffer.
  bit         m_in;
  logic [7:0] q[$];
  logic [7:0] m_cmd, m_len, m_pl;
  logic [1:0] m_code;
  bit         m_plv, m_done, m_err;

  function automatic void model_reset();
    m_in = 0; q.delete();
    m_cmd = 0; m_len = 0; m_pl = 0; m_code = 0;
    m_plv = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int n;
    logic [7:0] sum;
    m_plv = 0; m_done = 0; m_err = 0;
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in = 1;
        q.delete();
      end
      return;
    end
    q.push_back(b);
    n = q.size();
    if (n == 1) begin
      m_cmd = b;
    end else if (n == 2) begin
      m_len = b;
      if (b > 16) begin
        m_err = 1; m_code = 2; m_in = 0;
      end
    end else if (n <= 2 + int'(m_len)) begin
      m_pl = b; m_plv = 1;
    end else begin
      sum = 0;
      for (int i = 0; i < n - 1; i++) sum = sum + q[i];
      if (sum == b) m_done = 1;
      else begin
        m_err = 1; m_code = 1;
      end
      m_in = 0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b,
                           input int hold,
                           input int gap);
    @(negedge sys_clk);
    uart_rec = 1'b1;
    uart_data_in = b;
    @(posedge sys_clk); #1;
    model_byte(b);
    stb_cyc = cyc;
    npl += int'(pl_valid);
    ndone += int'(frm_done);
    nerr += int'(frm_err);
    check("pulses", {29'd0, pl_valid, frm_done, frm_err},
          {29'd0, m_plv, m_done, m_err});
    check("pl_data", {24'd0, pl_data}, {24'd0, m_pl});
    check("err_code", {30'd0, err_code}, {30'd0, m_code});
    check("frm_cmd", {24'd0, frm_cmd}, {24'd0, m_cmd});
    check("frm_len", {24'd0, frm_len}, {24'd0, m_len});
    check("busy", {31'd0, busy}, {31'd0, m_in});
    for (int i = 1; i < hold; i++) begin
      @(posedge sys_clk); #1;
      npl += int'(pl_valid);
      ndone += int'(frm_done);
      nerr += int'(frm_err);
      check("hold_pulses", {29'd0, pl_valid, frm_done, frm_err}, 32'd0);
    end
    @(negedge sys_clk);
    uart_rec = 1'b0;
    uart_data_in = 8'd0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int hold);
    npl = 0; ndone = 0; nerr = 0;
    foreach (s[i]) send_byte(s[i], hold, 1);
  endtask

  function automatic logic [31:0] all_outs();
    return {2'd0, frm_cmd, frm_len, pl_data, pl_valid,
            frm_done, frm_err, err_code, busy};
  endfunction

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] f[$];
    logic [7:0] b, sum;
    int len, seen;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1 check("reset_outs", all_outs(), 32'd0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    s = '{8'hA5, 8'h03, 8'h02, 8'h10, 8'h20, 8'h35};
    send_seq(s, 4);
    check("good_npl", npl, 2);
    check("good_done", ndone, 1);
    check("good_err", nerr, 0);
    check("good_cmd", {24'd0, frm_cmd}, 32'h03);
    check("good_len", {24'd0, frm_len}, 32'h02);

    s = '{8'hA5, 8'h03, 8'h02, 8'h10, 8'h20, 8'h36};
    send_seq(s, 3);
    check("badcs_npl", npl, 2);
    check("badcs_err", nerr, 1);
    check("badcs_done", ndone, 0);
    check("badcs_code", {30'd0, err_code}, 32'd1);
    check("badcs_busy", {31'd0, busy}, 32'd0);

    s = '{8'hA5, 8'h07, 8'h11};
    send_seq(s, 2);
    check("len_err", nerr, 1);
    check("len_code", {30'd0, err_code}, 32'd2);
    s = '{8'hA5, 8'h07, 8'h00, 8'h07};
    send_seq(s, 2);
    check("zero_done", ndone, 1);
    check("zero_npl", npl, 0);

    s = '{8'hA5, 8'h01};
    send_seq(s, 2);
    seen = 0;
    for (int i = 0; i < 50100 && !seen; i++) begin
      @(posedge sys_clk); #1;
      if (frm_err) seen = 1;
    end
    check("to_latency", cyc - stb_cyc, 50000);
    check("to_code", {30'd0, err_code}, 32'd3);
    check("to_busy", {31'd0, busy}, 32'd0);
    m_in = 0; q.delete(); m_code = 3;
    s = '{8'hA5, 8'h01, 8'h00, 8'h01};
    send_seq(s, 2);
    check("after_to_done", ndone, 1);

    s = '{8'h00, 8'hFF, 8'hA5, 8'hFF, 8'h02, 8'h80, 8'h81, 8'h02};
    send_seq(s, 13);
    check("wrap_npl", npl, 2);
    check("wrap_done", ndone, 1);
    check("wrap_pl", {24'd0, pl_data}, 32'h81);

    s = '{8'hA5, 8'h05, 8'h03, 8'h11, 8'h22};
    send_seq(s, 2);
    @(negedge sys_clk) sys_rst_n = 1'b0;
    #1 check("midrst_outs", all_outs(), 32'd0);
    model_reset();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    s = '{8'hA5, 8'h03, 8'h02, 8'h10, 8'h20, 8'h35};
    send_seq(s, 3);
    check("midrst_done", ndone, 1);
    check("midrst_npl", npl, 2);

    for (int fr = 0; fr < 40; fr++) begin
      f.delete();
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        f.push_back(b);
      end
      f.push_back(8'hA5);
      len = $urandom_range(0, 18);
      b = 8'($urandom);
      f.push_back(b);
      sum = b;
      f.push_back(8'(len));
      sum = sum + 8'(len);
      if (len <= 16) begin
        for (int j = 0; j < len; j++) begin
          b = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
          f.push_back(b);
          sum = sum + b;
        end
        if ($urandom_range(0, 3) == 0) sum = sum ^ 8'(1 << $urandom_range(0, 7));
        f.push_back(sum);
      end
      foreach (f[i])
        send_byte(f[i], $urandom_range(1, 13), $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the 2 Mbps UART receiver (50 MHz sys_clk).
- Takes its byte-complete flag and byte data, and turns the raw byte stream into checked command frames.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHECKSUM.
- Streams payload bytes to the command logic and reports frame completion or error with single-cycle pulses.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, largest legal LEN value (payload bytes).
- TIMEOUT_CYC, 50000, idle sys_clk cycles allowed between bytes inside a frame (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter; must hold TIMEOUT_CYC-1.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- uart_rec  in  1  byte-complete flag from the UART receiver; high for several cycles per byte; the rising edge marks a new byte.
- uart_data_in  in  8  received byte; valid while uart_rec is high, 0 otherwise.
- frm_cmd  out  8  CMD byte of the current/last frame.
- frm_len  out  8  LEN byte of the current/last frame.
- pl_data  out  8  payload byte; qualified by pl_valid.
- pl_valid  out  1  one-cycle pulse per payload byte.
- frm_done  out  1  one-cycle pulse; frame received with a good checksum.
- frm_err  out  1  one-cycle pulse; frame aborted.
- err_code  out  2  reason for the last frm_err: 1 = checksum, 2 = LEN > MAX_LEN, 3 = timeout.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; rec_last 0; checksum, payload count and timeout counter all 0.
- Byte strobe: stb = uart_rec & ~rec_last, where rec_last is uart_rec registered once.
  - Byte value is uart_data_in sampled at that same clock edge.
  - Exactly one stb per uart_rec high period, regardless of how long it stays high.
- All outputs are registered. Pulses (pl_valid, frm_done, frm_err) are high for exactly one cycle, in the cycle after the edge where stb is sampled (latency 1).
- FSM states: IDLE, CMD, LEN, PAYLOAD, CSUM. Transitions occur only on stb unless noted.
  - IDLE: byte == SYNC_BYTE -> CMD; any other byte is silently dropped.
  - CMD: frm_cmd <= byte; csum <= byte; -> LEN.
  - LEN: frm_len <= byte; csum <= csum + byte.
    - byte > MAX_LEN: frm_err, err_code = 2, -> IDLE.
    - byte == 0: -> CSUM.
    - otherwise: cnt <= 0, -> PAYLOAD.
  - PAYLOAD: pl_data <= byte; pl_valid pulse; csum <= csum + byte; cnt <= cnt + 1.
    - When cnt == frm_len - 1 -> CSUM.
  - CSUM: byte == csum -> frm_done; else frm_err, err_code = 1. Then -> IDLE.
  - A SYNC_BYTE value inside CMD, LEN, PAYLOAD or CSUM is ordinary data; there is no resync.
- Checksum: 8-bit sum of CMD, LEN and all payload bytes, wrapping modulo 256; SYNC is excluded.
- Timeout counter:
  - Cleared on every stb and whenever the state is IDLE; increments otherwise.
  - Reaching TIMEOUT_CYC-1 in a non-IDLE state: frm_err, err_code = 3, -> IDLE, counter cleared.
  - stb and timeout in the same cycle: the byte wins and the timeout is discarded.
- Output hold rules:
  - frm_cmd, frm_len and pl_data hold until overwritten.
  - err_code holds until the next frm_err.
  - busy is combinational from the state register.
- Frames are streamed. pl_valid bytes are emitted before the checksum is known, so the consumer discards buffered payload on frm_err.
- Back-to-back frames are supported: SYNC may arrive on the first stb after CSUM.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0; no pulse is generated.

Test Plan:
- Good frame: bytes A5 03 02 10 20 35 -> pl_valid twice (pl_data 10 then 20), frm_cmd = 03, frm_len = 02, frm_done one cycle after the 35 stb, frm_err never set.
- Bad checksum: A5 03 02 10 20 36 -> two pl_valid pulses, then frm_err with err_code = 1, no frm_done, busy = 0 afterwards.
- Length error and zero length:
  - A5 07 11 -> frm_err, err_code = 2 immediately after the LEN stb.
  - Then A5 07 00 07 -> frm_done with no pl_valid.
- Timeout: A5 01, then no bytes for 50000 cycles -> frm_err, err_code = 3, busy falls; a following A5 01 00 01 -> frm_done.
- Junk and wrap:
  - 00 FF A5 are accepted as a SYNC after junk.
  - Then FF 02 80 81 with checksum 02 (sum FF+02+80+81 = 0x202 -> 02) -> frm_done.
  - uart_rec held high 13 cycles per byte produces exactly one pl_valid per payload byte.
- Reset mid-frame: assert sys_rst_n = 0 during PAYLOAD -> all outputs 0, state IDLE; the next complete frame parses correctly.
